// File: rtl/friscv_dose_scheduler.sv
// friscv_dose_scheduler: arbitrates latched juice requests onto one pump and runs a timed, re-measured dose; FRISCV_RR_EN selects round-robin arbitration
module friscv_dose_scheduler #(
  parameter int TICK_DIV        = 50000,
  parameter int DOSE_MS         = 3000,
  parameter int MEAS_PERIOD_MS  = 100,
  parameter int MEAS_TIMEOUT_MS = 50,
  parameter int DIST_W          = 12,
  parameter int DIST_MAX        = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              habilita,
  input  logic              req_suco_1,
  input  logic              req_suco_2,
  input  logic              pronto,
  input  logic [DIST_W-1:0] distancia,
  output logic              medir,
  output logic              ativa_bomba_1,
  output logic              ativa_bomba_2,
  output logic              ocupado,
  output logic              concluido,
  output logic              erro_copo,
  output logic [3:0]        db_estado
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DOSE_MS + 1);
  localparam int QW = $clog2(MEAS_PERIOD_MS + 1);
  localparam int TW = $clog2(MEAS_TIMEOUT_MS + 1);
  typedef enum logic [3:0] {
    OCIOSO = 4'd0, ARBITRA = 4'd1, MEDE = 4'd2, AGUARDA = 4'd3, BOMBEIA = 4'd4,
    REMEDE = 4'd5, REAGUARDA = 4'd6, FIM = 4'd7, ABORTA = 4'd8
  } state_t;
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic [DW-1:0] dose;
  logic [QW-1:0] per;
  logic [TW-1:0] tmo;
  logic req_q1, req_q2, pend_1, pend_2, sel, sel_next;
  logic tick, copo_ok, dose_done, per_done, tmo_done, pumping, waiting, clr_pend, set_1, set_2;

  assign tick      = pre == PW'(TICK_DIV - 1);
  assign copo_ok   = distancia != '0 && distancia <= DIST_W'(DIST_MAX);
  assign dose_done = dose == DW'(DOSE_MS);
  assign per_done  = per == QW'(MEAS_PERIOD_MS);
  assign tmo_done  = tmo == TW'(MEAS_TIMEOUT_MS);
  assign pumping   = state inside {BOMBEIA, REMEDE, REAGUARDA};
  assign waiting   = state inside {AGUARDA, REAGUARDA};
  assign set_1     = habilita && req_suco_1 && !req_q1;
  assign set_2     = habilita && req_suco_2 && !req_q2;
  assign clr_pend  = (state == AGUARDA && state_nx == BOMBEIA) || (state != ABORTA && state_nx == ABORTA);

`ifdef FRISCV_RR_EN
  // rr holds the last served juice as a sel value, so reset to juice 2 lets juice 1 win first
  logic rr;
  assign sel_next = pend_1 && pend_2 ? !rr : pend_2;
  always_ff @(posedge clock or posedge reset)
    if (reset) rr <= 1'b1;
    else if (state == ARBITRA) rr <= sel_next;
`else
  assign sel_next = !pend_1;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      OCIOSO:    if (pend_1 || pend_2) state_nx = ARBITRA;
      ARBITRA:   state_nx = MEDE;
      MEDE:      state_nx = AGUARDA;
      AGUARDA:   if (pronto) state_nx = copo_ok ? BOMBEIA : ABORTA;
                 else if (tmo_done) state_nx = ABORTA;
      BOMBEIA:   if (dose_done) state_nx = FIM;
                 else if (per_done) state_nx = REMEDE;
      REMEDE:    state_nx = REAGUARDA;
      REAGUARDA: if ((pronto && !copo_ok) || tmo_done) state_nx = ABORTA;
                 else if (dose_done) state_nx = FIM;
                 else if (pronto) state_nx = BOMBEIA;
      default:   state_nx = OCIOSO;
    endcase
    if (!habilita) state_nx = OCIOSO;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= OCIOSO;
      pre    <= '0;
      dose   <= '0;
      per    <= '0;
      tmo    <= '0;
      req_q1 <= 1'b0;
      req_q2 <= 1'b0;
      pend_1 <= 1'b0;
      pend_2 <= 1'b0;
      sel    <= 1'b0;
    end else begin
      state  <= state_nx;
      pre    <= tick ? '0 : pre + 1'b1;
      dose   <= !pumping ? '0 : tick && !dose_done ? dose + 1'b1 : dose;
      per    <= state != BOMBEIA ? '0 : tick && !per_done ? per + 1'b1 : per;
      tmo    <= !waiting ? '0 : tick && !tmo_done ? tmo + 1'b1 : tmo;
      req_q1 <= req_suco_1;
      req_q2 <= req_suco_2;
      pend_1 <= habilita && (set_1 || (pend_1 && !(clr_pend && !sel)));
      pend_2 <= habilita && (set_2 || (pend_2 && !(clr_pend && sel)));
      if (state == ARBITRA) sel <= sel_next;
    end

  assign medir         = state inside {MEDE, REMEDE};
  assign ativa_bomba_1 = pumping && !sel;
  assign ativa_bomba_2 = pumping && sel;
  assign ocupado       = state != OCIOSO;
  assign concluido     = state == FIM;
  assign erro_copo     = state == ABORTA;
  assign db_estado     = state > ABORTA ? 4'hE : state;
endmodule

// File: tb/tb_friscv_dose_scheduler.sv
// tb_friscv_dose_scheduler: randomized directed scenarios checked against a transaction-level model of dose outcome and arbitration order
module tb_friscv_dose_scheduler;
  localparam int TD = 4, DOSE = 10, PER = 3, TMO = 5, DMAX = 10;
  logic clock = 1'b0;
  logic reset, habilita, req_suco_1, req_suco_2, pronto;
  logic [11:0] distancia;
  logic medir, ativa_bomba_1, ativa_bomba_2, ocupado, concluido, erro_copo;
  logic [3:0] db_estado;
  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  friscv_dose_scheduler #(
    .TICK_DIV(TD), .DOSE_MS(DOSE), .MEAS_PERIOD_MS(PER), .MEAS_TIMEOUT_MS(TMO), .DIST_W(12), .DIST_MAX(DMAX)
  ) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .req_suco_1(req_suco_1), .req_suco_2(req_suco_2),
    .pronto(pronto), .distancia(distancia), .medir(medir), .ativa_bomba_1(ativa_bomba_1),
    .ativa_bomba_2(ativa_bomba_2), .ocupado(ocupado), .concluido(concluido), .erro_copo(erro_copo),
    .db_estado(db_estado)
  );

  // monitor: running totals of observed output activity, sampled mid-cycle
  int cyc = 0, n_p1 = 0, n_p2 = 0, n_both = 0, n_medir = 0, n_conc = 0, n_erro = 0, n_ocup = 0;
  int medir_cyc = 0, erro_cyc = 0;
  logic [1:0] end_pumps = 2'b00;
  logic on_q = 1'b0;
  int served[$];
  initial forever begin
    @(negedge clock);
    cyc++;
    if (reset === 1'b0) begin
      if (ativa_bomba_1) n_p1++;
      if (ativa_bomba_2) n_p2++;
      if (ativa_bomba_1 && ativa_bomba_2) n_both++;
      if (medir) begin n_medir++; medir_cyc = cyc; end
      if (concluido) n_conc++;
      if (erro_copo) begin n_erro++; erro_cyc = cyc; end
      if (concluido || erro_copo) end_pumps = {ativa_bomba_2, ativa_bomba_1};
      if (ocupado) n_ocup++;
      if ((ativa_bomba_1 || ativa_bomba_2) && !on_q) served.push_back(ativa_bomba_1 ? 1 : 2);
    end
    on_q = ativa_bomba_1 | ativa_bomba_2;
  end

  // sensor: answers each medir two cycles later with the next distance from dist_tab
  logic resp_en = 1'b1;
  int n_resp = 0, resp_base = 0;
  logic [11:0] dist_tab [8];
  initial begin
    logic [11:0] d;
    pronto = 1'b0;
    distancia = '0;
    forever begin
      @(negedge clock);
      if (medir === 1'b1 && resp_en) begin
        d = dist_tab[3'(n_resp - resp_base)];
        n_resp++;
        repeat (2) @(negedge clock);
        pronto = 1'b1;
        distancia = d;
        @(negedge clock);
        pronto = 1'b0;
        distancia = 12'($urandom);
      end
    end
  end

  // reference model: last served juice, as the arbitration rule sees it
  int rr_last = 2;
  function automatic int arb(input bit p1, input bit p2);
`ifdef FRISCV_RR_EN
    return (p1 && p2) ? (rr_last == 1 ? 2 : 1) : (p1 ? 1 : 2);
`else
    return p1 ? 1 : 2;
`endif
  endfunction

  function automatic int srv(input int k);
    return k < served.size() ? served[k] : 0;
  endfunction

  function automatic logic [11:0] bad_dist();
    return $urandom_range(0, 1) ? 12'd0 : 12'($urandom_range(DMAX + 1, 4095));
  endfunction

  int b_p1, b_p2, b_medir, b_conc, b_erro, b_srv;
  task automatic snap();
    b_p1 = n_p1; b_p2 = n_p2; b_medir = n_medir; b_conc = n_conc; b_erro = n_erro;
    b_srv = served.size(); resp_base = n_resp;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic pulse(input bit r1, input bit r2);
    @(negedge clock);
    req_suco_1 = r1;
    req_suco_2 = r2;
    @(negedge clock);
    req_suco_1 = 1'b0;
    req_suco_2 = 1'b0;
  endtask

  task automatic wait_events(input string tag, input int k, input int lim);
    int i = 0;
    while ((n_conc + n_erro - b_conc - b_erro) < k && i < lim) begin cyc_n(1); i++; end
    chk({tag, "_finished"}, int'(i < lim), 1);
    cyc_n(3);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int lim);
    int i = 0;
    while (db_estado !== s && i < lim) begin cyc_n(1); i++; end
    chk({tag, "_reached"}, int'(i < lim), 1);
  endtask

  task automatic all_good();
    for (int i = 0; i < 8; i++) dist_tab[i] = 12'($urandom_range(1, DMAX));
  endtask

  task automatic check_good(input string tag, input int j);
    chk({tag, "_conc"}, n_conc - b_conc, 1);
    chk({tag, "_erro"}, n_erro - b_erro, 0);
    chk_rng({tag, "_pump_on"}, j == 1 ? n_p1 - b_p1 : n_p2 - b_p2, (DOSE - 1) * TD, DOSE * TD + 2);
    chk({tag, "_other_pump"}, j == 1 ? n_p2 - b_p2 : n_p1 - b_p1, 0);
    chk({tag, "_medir"}, n_medir - b_medir, 3);
    chk({tag, "_served"}, srv(b_srv), j);
    chk({tag, "_end_pumps"}, int'(end_pumps), 0);
    chk({tag, "_idle"}, int'(ocupado), 0);
  endtask

  task automatic check_idle_after(input string tag);
    int o;
    o = n_ocup;
    cyc_n(10);
    chk({tag, "_pend_cleared"}, n_ocup - o, 0);
  endtask

  initial begin
    int j, k, n, first;
    reset = 1'b1; habilita = 1'b0; req_suco_1 = 1'b0; req_suco_2 = 1'b0;
    all_good();
    cyc_n(3);
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_outputs", int'({medir, ativa_bomba_1, ativa_bomba_2, ocupado, concluido, erro_copo}), 0);
    @(negedge clock);
    reset = 1'b0;
    habilita = 1'b1;
    cyc_n(2);
    chk("idle_after_rst", int'(ocupado), 0);

    for (int r = 0; r < 3; r++) begin
      j = $urandom_range(1, 2);
      all_good();
      cyc_n($urandom_range(0, 7));
      snap();
      pulse(j == 1, j == 2);
      wait_events("good", 1, 400);
      check_good("good", j);
      rr_last = j;
    end

    for (int r = 0; r < 2; r++) begin
      j = $urandom_range(1, 2);
      all_good();
      dist_tab[0] = bad_dist();
      snap();
      pulse(j == 1, j == 2);
      wait_events("nocup", 1, 200);
      chk("nocup_erro", n_erro - b_erro, 1);
      chk("nocup_conc", n_conc - b_conc, 0);
      chk("nocup_pumps", n_p1 + n_p2 - b_p1 - b_p2, 0);
      chk("nocup_medir", n_medir - b_medir, 1);
      rr_last = j;
      check_idle_after("nocup");
    end

    for (int r = 0; r < 2; r++) begin
      j = $urandom_range(1, 2);
      n = $urandom_range(1, 2);
      all_good();
      dist_tab[n] = bad_dist();
      cyc_n($urandom_range(0, 7));
      snap();
      pulse(j == 1, j == 2);
      wait_events("cuplost", 1, 400);
      chk("cuplost_erro", n_erro - b_erro, 1);
      chk("cuplost_conc", n_conc - b_conc, 0);
      chk_rng("cuplost_pump_on", j == 1 ? n_p1 - b_p1 : n_p2 - b_p2, 1, DOSE * TD - 1);
      chk("cuplost_end_pumps", int'(end_pumps), 0);
      chk("cuplost_medir", n_medir - b_medir, n + 1);
      rr_last = j;
      check_idle_after("cuplost");
    end

    j = $urandom_range(1, 2);
    resp_en = 1'b0;
    cyc_n($urandom_range(0, 7));
    snap();
    pulse(j == 1, j == 2);
    wait_events("timeout", 1, 200);
    chk("timeout_erro", n_erro - b_erro, 1);
    chk("timeout_conc", n_conc - b_conc, 0);
    chk("timeout_pumps", n_p1 + n_p2 - b_p1 - b_p2, 0);
    chk_rng("timeout_latency", erro_cyc - medir_cyc, (TMO - 1) * TD, TMO * TD + 3);
    resp_en = 1'b1;
    rr_last = j;

    for (int r = 0; r < 3; r++) begin
      if (r == 2) begin
        all_good();
        snap();
        pulse(1'b1, 1'b0);
        wait_events("solo1", 1, 400);
        check_good("solo1", 1);
        rr_last = 1;
      end
      all_good();
      cyc_n($urandom_range(0, 7));
      snap();
      pulse(1'b1, 1'b1);
      wait_events("both", 2, 800);
      first = arb(1'b1, 1'b1);
      chk("both_conc", n_conc - b_conc, 2);
      chk("both_erro", n_erro - b_erro, 0);
      chk("both_first", srv(b_srv), first);
      chk("both_second", srv(b_srv + 1), 3 - first);
      rr_last = 3 - first;
    end

    j = $urandom_range(1, 2);
    k = 3 - j;
    all_good();
    snap();
    pulse(j == 1, j == 2);
    wait_state("hab_bombeia", 4'd4, 100);
    cyc_n($urandom_range(0, 3));
    pulse(k == 1, k == 2);
    habilita = 1'b0;
    cyc_n(1);
    chk("hab_estado", int'(db_estado), 0);
    chk("hab_pumps", int'({ativa_bomba_1, ativa_bomba_2}), 0);
    cyc_n(2);
    habilita = 1'b1;
    check_idle_after("hab");
    chk("hab_no_pulses", n_conc + n_erro - b_conc - b_erro, 0);
    rr_last = j;

    j = $urandom_range(1, 2);
    all_good();
    snap();
    pulse(j == 1, j == 2);
    wait_state("rst_reaguarda", 4'd6, 200);
    reset = 1'b1;
    #1;
    chk("async_rst_outputs", int'({medir, ativa_bomba_1, ativa_bomba_2, ocupado, concluido, erro_copo}), 0);
    chk("async_rst_estado", int'(db_estado), 0);
    @(negedge clock);
    reset = 1'b0;
    rr_last = 2;
    check_idle_after("rst");
    chk("rst_no_pulses", n_conc + n_erro - b_conc - b_erro, 0);

    all_good();
    snap();
    pulse(1'b1, 1'b1);
    wait_events("post_rst_both", 2, 800);
    first = arb(1'b1, 1'b1);
    chk("post_rst_first", srv(b_srv), first);
    chk("post_rst_second", srv(b_srv + 1), 3 - first);

    chk("never_both_pumps", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
